// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller.
// No logic of its own; widths, FSM states and the MEM/WB bubble value.
// Imported by mem_stage_ctrl and mem_wb_reg.
package mem_stage_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Control half of the MEM/WB register: cleared on a bubble
  typedef struct packed {
    logic regwrite;
    logic halt;
  } wb_ctrl_t;

  // Data half of the MEM/WB register: held across bubbles
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_data_t;

  localparam wb_ctrl_t WB_BUBBLE = '{regwrite: 1'b0, halt: 1'b0};

  // Writeback mux: PC-save beats memory data, memory data beats ALU result.
  // An aborted load returns the error pattern instead of the bus value.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic              pcs,
    input logic              memtoreg,
    input logic              aborted,
    input logic [DATA_W-1:0] pc_inc,
    input logic [DATA_W-1:0] rdata,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] err_val
  );
    logic [DATA_W-1:0] v;
    if (pcs)           v = pc_inc;
    else if (memtoreg) v = aborted ? err_val : rdata;
    else               v = alu;
    return v;
  endfunction

endpackage

// File: rtl/dff.sv
// Generic enabled D flip-flop bank with asynchronous active-high reset.
// Latency: 1 cycle from d_i to q_o when en_i is high.
// No flow control; holds its value while en_i is low.
module dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Capture d_i when enabled, return to the reset value asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_q <= RST_VAL;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: load a full entry, insert a bubble, or hold.
// Latency: 1 cycle. Load has priority over bubble.
// A bubble clears only the control bits; destination and data are held.
module mem_wb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  logic     bubble_i,
  input  wb_ctrl_t ctrl_i,
  input  wb_data_t data_i,
  output wb_ctrl_t ctrl_o,
  output wb_data_t data_o
);

  logic     ctrl_en;
  wb_ctrl_t ctrl_d;

  assign ctrl_en = load_i | bubble_i;
  assign ctrl_d  = load_i ? ctrl_i : WB_BUBBLE;

  dff #(.WIDTH($bits(wb_ctrl_t))) u_ctrl (
    .clk  (clk),
    .rst  (rst),
    .en_i (ctrl_en),
    .d_i  (ctrl_d),
    .q_o  (ctrl_o)
  );

  dff #(.WIDTH($bits(wb_data_t))) u_data (
    .clk  (clk),
    .rst  (rst),
    .en_i (load_i),
    .d_i  (data_i),
    .q_o  (data_o)
  );

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data-memory req/ready handshake and loads MEM/WB.
// Latency: MEM/WB loads in the cycle mem_ready (or a timeout abort) arrives; 0 stalls for zero-wait memory.
// Backpressure: mem_stall freezes upstream while an access is outstanding. Optional MEM_STALL_CNT_EN adds stall_cnt.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERR_RDATA      = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,      // active-high despite the name
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              PCS,
  input  logic              HALT,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic [REG_W-1:0]  Rd,
  input  logic [DATA_W-1:0] PC_Inc,
  input  logic [DATA_W-1:0] dataRt,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_stall,
  output logic              RegWrite_WB,
  output logic [REG_W-1:0]  Rd_WB,
  output logic [DATA_W-1:0] wb_data,
  output logic              HALT_WB,
`ifdef MEM_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              mem_err
);

  localparam logic              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [DATA_W-1:0] TMO_LAST = DATA_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tcnt_q, tcnt_d;
  logic              err_q, err_d;

  logic     op, idle, busy, abort, complete;
  wb_ctrl_t wb_ctrl_in, wb_ctrl_out;
  wb_data_t wb_data_in, wb_data_out;

  assign op   = MemRead | MemWrite;
  assign idle = (state_q == IDLE);
  assign busy = (state_q == BUSY);

  // Reset gates the request combinationally so it drops the instant reset rises,
  // even though the held EX/MEM inputs still describe a memory op.
  assign mem_req   = ~rst_n & ((idle & op) | busy);
  assign mem_wr    = MemWrite;
  assign mem_addr  = ALU_Out;
  assign mem_wdata = dataRt;

  // Abort on the last allowed BUSY cycle; a ready in the same cycle wins
  assign abort     = busy & TMO_EN & (tcnt_q == TMO_LAST) & ~mem_ready;
  assign mem_stall = mem_req & ~mem_ready & ~abort;

  // Anything that is not a stall (and not halted) retires an instruction into MEM/WB
  assign complete  = (idle & ~op) | (mem_req & (mem_ready | abort));

  assign wb_ctrl_in.regwrite = RegWrite;
  assign wb_ctrl_in.halt     = HALT;
  assign wb_data_in.rd       = Rd;
  assign wb_data_in.data     = wb_select(PCS, MemtoReg, abort, PC_Inc, mem_rdata, ALU_Out, ERR_RDATA);

  // Next-state logic for the access FSM, timeout counter and sticky error
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (op & ~mem_ready) begin
          state_d = BUSY;
          tcnt_d  = '0;
        end else if (HALT) begin
          state_d = HALTED;
        end
      end
      BUSY: begin
        tcnt_d = tcnt_q + DATA_W'(1);
        if (mem_ready | abort) begin
          state_d = HALT ? HALTED : IDLE;
          if (abort) err_d = 1'b1;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // State, timeout counter and error flag registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_err = err_q;

  mem_wb_reg u_mem_wb (
    .clk      (clk),
    .rst      (rst_n),
    .load_i   (complete),
    .bubble_i (mem_stall),
    .ctrl_i   (wb_ctrl_in),
    .data_i   (wb_data_in),
    .ctrl_o   (wb_ctrl_out),
    .data_o   (wb_data_out)
  );

  assign RegWrite_WB = wb_ctrl_out.regwrite;
  assign HALT_WB     = wb_ctrl_out.halt;
  assign Rd_WB       = wb_data_out.rd;
  assign wb_data     = wb_data_out.data;

`ifdef MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                                    stall_cnt_q <= '0;
    else if (mem_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed steps plus randomized instruction stream.
// Expected values come from a per-instruction model: access age, retire/bubble rules.
// Inputs change only when the previous cycle was not stalled.
module tb_mem_stage_ctrl;

  localparam int          TMO  = 4;
  localparam logic [15:0] ERRV = 16'hEEEE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite, RegWrite, MemtoReg, PCS, HALT, mem_ready;
  logic [15:0] ALU_Out, PC_Inc, dataRt, mem_rdata;
  logic [3:0]  Rd;
  logic        mem_req, mem_wr, mem_stall, RegWrite_WB, HALT_WB, mem_err;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  Rd_WB;
`ifdef MEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERRV)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .PCS(PCS), .HALT(HALT), .ALU_Out(ALU_Out), .Rd(Rd), .PC_Inc(PC_Inc), .dataRt(dataRt),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .RegWrite_WB(RegWrite_WB), .Rd_WB(Rd_WB), .wb_data(wb_data),
    .HALT_WB(HALT_WB),
`ifdef MEM_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .mem_err(mem_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: halted flag, age of the outstanding access, MEM/WB contents
  bit          m_halted, m_err, m_rw, m_halt;
  int          m_age;
  logic [3:0]  m_rd;
  logic [15:0] m_wb;
  bit          last_stall;
  int          stall_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_err = 0; m_rw = 0; m_halt = 0; m_age = 0;
    m_rd = '0; m_wb = '0; last_stall = 0;
  endtask

  task automatic set_nop();
    MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0; PCS = 0; HALT = 0;
    ALU_Out = '0; PC_Inc = '0; dataRt = '0; Rd = '0;
  endtask

  task automatic check_reset_vals();
    check("rst_mem_req",  32'(mem_req), 32'(0));
    check("rst_stall",    32'(mem_stall), 32'(0));
    check("rst_regwrite", 32'(RegWrite_WB), 32'(0));
    check("rst_rd",       32'(Rd_WB), 32'(0));
    check("rst_wb_data",  32'(wb_data), 32'(0));
    check("rst_halt",     32'(HALT_WB), 32'(0));
    check("rst_err",      32'(mem_err), 32'(0));
  endtask

  // One clock: called just after a falling edge with inputs already driven
  task automatic cycle();
    bit op, req, abrt, stall;
    op    = MemRead | MemWrite;
    req   = !m_halted && (op || m_age > 0);
    abrt  = req && (TMO != 0) && (m_age == TMO) && !mem_ready;
    stall = req && !mem_ready && !abrt;
    #1;
    check("mem_req",   32'(mem_req), 32'(req));
    check("mem_stall", 32'(mem_stall), 32'(stall));
    if (req) begin
      check("mem_wr",    32'(mem_wr), 32'(MemWrite ? 1'b1 : 1'b0));
      check("mem_addr",  32'(mem_addr), 32'(ALU_Out));
      check("mem_wdata", 32'(mem_wdata), 32'(dataRt));
    end
    last_stall = stall;
    if (stall) stall_seen++;
    @(posedge clk);
    if (!m_halted) begin
      if (stall) begin
        m_rw = 0; m_halt = 0; m_age++;
      end else begin
        m_rw = RegWrite; m_rd = Rd; m_halt = HALT;
        if (PCS)           m_wb = PC_Inc;
        else if (MemtoReg) m_wb = abrt ? ERRV : mem_rdata;
        else               m_wb = ALU_Out;
        if (abrt) m_err = 1;
        m_age = 0;
        if (HALT) m_halted = 1;
      end
    end
    #1;
    check("RegWrite_WB", 32'(RegWrite_WB), 32'(m_rw));
    check("Rd_WB",       32'(Rd_WB), 32'(m_rd));
    check("wb_data",     32'(wb_data), 32'(m_wb));
    check("HALT_WB",     32'(HALT_WB), 32'(m_halt));
    check("mem_err",     32'(mem_err), 32'(m_err));
    @(negedge clk);
  endtask

  initial begin
    int kind, lat, wcnt;
    kind = 0; lat = 0; wcnt = 0;
    set_nop();
    mem_ready = 0; mem_rdata = '0;
    rst_n = 1;
    #1;
    check_reset_vals();
    @(negedge clk); @(negedge clk);
    rst_n = 0;
    model_reset();

    // Load with three wait cycles
    MemRead = 1; MemtoReg = 1; RegWrite = 1; ALU_Out = 16'h0040; Rd = 4'd3;
    stall_seen = 0;
    for (int i = 0; i < 3; i++) begin mem_ready = 0; cycle(); end
    mem_ready = 1; mem_rdata = 16'hBEEF; cycle();
    check("load_stalls", 32'(stall_seen), 32'(3));
    check("load_rw",     32'(RegWrite_WB), 32'(1));
    check("load_rd",     32'(Rd_WB), 32'(3));
    check("load_data",   32'(wb_data), 32'(16'hBEEF));

    // Zero-wait store
    set_nop(); MemWrite = 1; ALU_Out = 16'h0010; dataRt = 16'h1234; mem_ready = 1;
    stall_seen = 0;
    cycle();
    check("store_stalls", 32'(stall_seen), 32'(0));
    check("store_rw",     32'(RegWrite_WB), 32'(0));

    // ALU result then PC save, no memory traffic
    set_nop(); RegWrite = 1; ALU_Out = 16'h00AA; Rd = 4'd7; mem_ready = 0;
    cycle();
    check("alu_data", 32'(wb_data), 32'(16'h00AA));
    set_nop(); RegWrite = 1; PCS = 1; PC_Inc = 16'h0102; ALU_Out = 16'h0555; Rd = 4'd15;
    cycle();
    check("pcs_data", 32'(wb_data), 32'(16'h0102));

    // Load that never completes: aborted after the timeout
    set_nop(); MemRead = 1; MemtoReg = 1; RegWrite = 1; ALU_Out = 16'h0200; Rd = 4'd9;
    mem_ready = 0; mem_rdata = 16'h7777;
    stall_seen = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("tmo_stalls", 32'(stall_seen), 32'(4));
    check("tmo_err",    32'(mem_err), 32'(1));
    check("tmo_data",   32'(wb_data), 32'(ERRV));
    check("tmo_rw",     32'(RegWrite_WB), 32'(1));

    // A later access is still serviced
    set_nop(); MemRead = 1; MemtoReg = 1; RegWrite = 1; ALU_Out = 16'h0300; Rd = 4'd2;
    mem_ready = 0; cycle();
    mem_ready = 1; mem_rdata = 16'hC0DE; cycle();
    check("after_tmo_data", 32'(wb_data), 32'(16'hC0DE));

    // Randomized instruction stream
    for (int t = 0; t < 400; t++) begin
      if (!last_stall) begin
        set_nop();
        kind = $urandom_range(0, 4);
        lat  = $urandom_range(0, 6);
        wcnt = 0;
        ALU_Out = 16'($urandom); PC_Inc = 16'($urandom);
        dataRt  = 16'($urandom); Rd = 4'($urandom);
        case (kind)
          1: RegWrite = 1;
          2: begin RegWrite = 1; PCS = 1; end
          3: begin
            MemRead = 1; RegWrite = 1'($urandom_range(0, 1));
            MemtoReg = ($urandom_range(0, 3) != 0); PCS = ($urandom_range(0, 3) == 0);
          end
          4: begin MemWrite = 1; MemRead = 1'($urandom_range(0, 1)); end
          default: ;
        endcase
      end
      mem_ready = (kind >= 3) ? (wcnt == lat) : 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      cycle();
      wcnt++;
    end

    // Reset pulsed while an access is outstanding
    set_nop(); MemRead = 1; MemtoReg = 1; RegWrite = 1; ALU_Out = 16'h0080; Rd = 4'd5;
    mem_ready = 0;
    cycle(); cycle();
    rst_n = 1;
    #1;
    check_reset_vals();
    model_reset();
    @(negedge clk);
    rst_n = 0;
    mem_ready = 0; cycle();
    mem_ready = 1; mem_rdata = 16'h5A5A; cycle();
    check("post_rst_data", 32'(wb_data), 32'(16'h5A5A));
    check("post_rst_rd",   32'(Rd_WB), 32'(5));

    // HALT retires, then the stage stays frozen
    set_nop(); HALT = 1; ALU_Out = 16'h1111; Rd = 4'd1; mem_ready = 0;
    cycle();
    check("halt_set", 32'(HALT_WB), 32'(1));
    set_nop(); MemRead = 1; MemtoReg = 1; RegWrite = 1; ALU_Out = 16'h0400; Rd = 4'd4;
    for (int i = 0; i < 3; i++) cycle();
    check("halt_sticky", 32'(HALT_WB), 32'(1));
    check("halt_req",    32'(mem_req), 32'(0));
    check("halt_stall",  32'(mem_stall), 32'(0));
    check("halt_rw",     32'(RegWrite_WB), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller that consumes the EX/MEM pipeline-register outputs. It drives a multi-cycle data-memory request/ready handshake and stalls the pipeline while an access is outstanding. It captures the selected writeback value and control bits into the MEM/WB register, and enters a terminal halted state after a HALT instruction retires through the stage.

Parameters:
TIMEOUT_CYCLES, 64, cycles waited in BUSY before an access is aborted; 0 disables the timeout.
ERR_RDATA, 16'h0000, value written back by a load aborted on timeout.

Ports:
clk  input  1  pipeline clock; all state on rising edge
rst_n  input  1  asynchronous, active-high reset (name fixed by codebase; asserted = 1)
MemRead  input  1  EX/MEM load control
MemWrite  input  1  EX/MEM store control
RegWrite  input  1  EX/MEM register-write control
MemtoReg  input  1  EX/MEM select memory data for writeback
PCS  input  1  EX/MEM select PC_Inc for writeback
HALT  input  1  EX/MEM halt marker
ALU_Out  input  16  memory address / ALU result
Rd  input  4  destination register
PC_Inc  input  16  PC+2 for PCS
dataRt  input  16  store data
mem_ready  input  1  memory completes current access this cycle
mem_rdata  input  16  load data, valid when mem_ready=1
mem_req  output  1  access request, held until mem_ready or abort
mem_wr  output  1  1 = store, 0 = load
mem_addr  output  16  = ALU_Out
mem_wdata  output  16  = dataRt
mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
RegWrite_WB  output  1  MEM/WB register write enable
Rd_WB  output  4  MEM/WB destination
wb_data  output  16  MEM/WB writeback value
HALT_WB  output  1  MEM/WB halt; sticky once set
mem_err  output  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY, HALTED. Reset: state=IDLE; RegWrite_WB=0, Rd_WB=0, wb_data=0, HALT_WB=0, mem_err=0; mem_req=0 immediately (async).
- op = MemRead|MemWrite. Both set: treated as store (mem_wr=1).
- mem_req = (IDLE & op) | BUSY. mem_wr, mem_addr, mem_wdata are combinational from the inputs. Upstream holds the EX/MEM inputs stable while mem_stall=1.
- mem_stall = mem_req & ~mem_ready & ~abort. A zero-wait memory (mem_ready in the request cycle) gives 0 stall cycles.
- IDLE & op & ~mem_ready -> BUSY; the timeout counter is cleared.
- BUSY & mem_ready -> IDLE (access complete). The counter increments each BUSY cycle; abort = BUSY & (TIMEOUT_CYCLES!=0) & (counter==TIMEOUT_CYCLES-1) & ~mem_ready. abort -> IDLE, mem_err<=1. mem_ready in the abort cycle wins (normal completion).
- Completion (IDLE with no op, or access completing/aborting) loads MEM/WB: RegWrite_WB=RegWrite, Rd_WB=Rd, HALT_WB=HALT, wb_data = PCS ? PC_Inc : MemtoReg ? (aborted ? ERR_RDATA : mem_rdata) : ALU_Out. PCS has priority over MemtoReg.
- While stalled, MEM/WB loads a bubble: RegWrite_WB=0, HALT_WB=0; Rd_WB and wb_data are held.
- Loading HALT=1 -> HALTED. HALTED: mem_req=0, mem_stall=0, MEM/WB holds its HALT entry (HALT_WB=1, RegWrite_WB=0). Exit only via reset.
- Reset mid-BUSY: request dropped, no writeback, counter cleared.

Optional Feature:
MEM_STALL_CNT_EN: adds output stall_cnt[15:0]. It increments every cycle mem_stall=1, saturates at 16'hFFFF, and resets to 0. Without the macro the port and counter do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package: state enum (IDLE/BUSY/HALTED), MEM/WB bubble constant, 16-bit data and 4-bit register-index widths.
- Sub-module mem_wb_reg: the MEM/WB register bank, with a load/bubble select and built from the existing dff cells.

Test Plan:
- Load, ALU_Out=16'h0040, Rd=3, MemtoReg=1, mem_ready after 3 cycles with rdata=16'hBEEF -> mem_stall high 3 cycles, 3 bubbles, then RegWrite_WB=1, Rd_WB=3, wb_data=16'hBEEF.
- Store, ALU_Out=16'h0010, dataRt=16'h1234, zero-wait ready -> mem_req=1, mem_wr=1 for one cycle, mem_stall=0, RegWrite_WB=0.
- ALU op, ALU_Out=16'h00AA, RegWrite=1; PCS op, PC_Inc=16'h0102 -> wb_data 16'h00AA then 16'h0102, no mem_req.
- Load with mem_ready never asserted, TIMEOUT_CYCLES=4 -> stall 4 cycles, mem_err=1, wb_data=ERR_RDATA, RegWrite_WB=1; a later access is still serviced.
- HALT=1 followed by a load -> HALT_WB=1 sticky, mem_req stays 0, mem_stall 0.
- rst_n pulsed high during BUSY -> mem_req falls immediately, all outputs return to reset values, the next load completes normally.
